// File: rtl/edge_event_arbiter_pkg.sv
// Shared types and limits for the edge event arbiter.
// Optional overflow tracking is enabled with EDGE_EVENT_ARBITER_OVERFLOW_EN.
package edge_event_arbiter_pkg;

    localparam int EDGE_MAX_CH   = 32;
    localparam int EDGE_CH_W_MAX = 5;

    // One serialised event: channel index plus edge polarity.
    typedef struct packed {
        logic [EDGE_CH_W_MAX-1:0] ch;
        logic                     rising;
    } edge_evt_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/edge_pend_cell.sv
// Per-channel edge detector with rise/fall pending flags and age tracking.
// With EDGE_EVENT_ARBITER_OVERFLOW_EN defined, a sticky overflow bit records
// any edge that merged into an already pending flag of the same type.
module edge_pend_cell
    import edge_event_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic signal,
    input  logic rise_en,
    input  logic fall_en,
    input  logic grant,
    input  logic grant_rising,
    output logic rise_pend,
    output logic fall_pend,
    output logic rise_older
`ifdef EDGE_EVENT_ARBITER_OVERFLOW_EN
    ,
    output logic ovf,
    input  logic ovf_clr
`endif
);

    logic signal_r;
    logic rise_det;
    logic fall_det;
    logic rise_kept;
    logic fall_kept;
    logic rise_next;
    logic fall_next;
    logic age_next;

    // Edge detection, flag next-state (set beats clear) and age ordering.
    always_comb begin
        rise_det  = signal & ~signal_r & rise_en;
        fall_det  = ~signal & signal_r & fall_en;
        rise_kept = rise_pend & ~(grant & grant_rising);
        fall_kept = fall_pend & ~(grant & ~grant_rising);
        rise_next = rise_det | rise_kept;
        fall_next = fall_det | fall_kept;
        // A flag that survives this cycle is older than one set this cycle.
        if (rise_kept && fall_kept) begin
            age_next = rise_older;
        end else if (rise_kept) begin
            age_next = 1'b1;
        end else if (fall_kept) begin
            age_next = 1'b0;
        end else begin
            age_next = rise_det;
        end
    end

    // Sampled signal, pending flags and age bit; reset re-seeds signal_r
    // from the live line so no edge is seen on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            signal_r   <= signal;
            rise_pend  <= 1'b0;
            fall_pend  <= 1'b0;
            rise_older <= 1'b0;
        end else begin
            signal_r   <= signal;
            rise_pend  <= rise_next;
            fall_pend  <= fall_next;
            rise_older <= age_next;
        end
    end

`ifdef EDGE_EVENT_ARBITER_OVERFLOW_EN
    logic merge;

    assign merge = (rise_det & rise_kept) | (fall_det & fall_kept);

    // Sticky overflow: a merge in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (merge) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/edge_event_arbiter.sv
// Edge event arbiter: captures rising/falling edges on NUM_CH lines and
// serialises them round-robin onto a valid/ready event stream.
// Optional overflow reporting is enabled with EDGE_EVENT_ARBITER_OVERFLOW_EN.
module edge_event_arbiter
    import edge_event_arbiter_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] signal,
    input  logic [NUM_CH-1:0] rise_en,
    input  logic [NUM_CH-1:0] fall_en,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CH_W-1:0]   evt_ch,
    output logic              evt_rising,
    output logic [NUM_CH-1:0] pending
`ifdef EDGE_EVENT_ARBITER_OVERFLOW_EN
    ,
    output logic [NUM_CH-1:0] ovf,
    input  logic [NUM_CH-1:0] ovf_clr
`endif
);

    if (NUM_CH < 2 || NUM_CH > EDGE_MAX_CH) begin : g_bad_num_ch
        $error("edge_event_arbiter: NUM_CH out of range");
    end

    arb_state_e        state_reg;
    logic [CH_W-1:0]   rr_ptr_reg;
    logic [NUM_CH-1:0] rise_pend;
    logic [NUM_CH-1:0] fall_pend;
    logic [NUM_CH-1:0] rise_older;
    logic [NUM_CH-1:0] pend_any;
    logic [NUM_CH-1:0] grant_vec;
    logic              any_pend;
    logic [CH_W-1:0]   grant_ch;
    logic              grant_rising;
    logic [CH_W:0]     idx;
    logic              load;
    logic [CH_W-1:0]   rr_next;

    assign pend_any = rise_pend | fall_pend;
    assign pending  = pend_any;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cell
        assign grant_vec[gi] = load && (grant_ch == CH_W'(gi));

        edge_pend_cell u_cell (
            .clk          (clk),
            .rst          (rst),
            .signal       (signal[gi]),
            .rise_en      (rise_en[gi]),
            .fall_en      (fall_en[gi]),
            .grant        (grant_vec[gi]),
            .grant_rising (grant_rising),
            .rise_pend    (rise_pend[gi]),
            .fall_pend    (fall_pend[gi]),
            .rise_older   (rise_older[gi])
`ifdef EDGE_EVENT_ARBITER_OVERFLOW_EN
            ,
            .ovf          (ovf[gi]),
            .ovf_clr      (ovf_clr[gi])
`endif
        );
    end

    // Round-robin search upward from rr_ptr_reg, then pick the older edge type.
    always_comb begin
        any_pend = 1'b0;
        grant_ch = '0;
        idx      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = {1'b0, rr_ptr_reg} + (CH_W+1)'(i);
            if (idx >= (CH_W+1)'(NUM_CH)) begin
                idx = idx - (CH_W+1)'(NUM_CH);
            end
            if (!any_pend && pend_any[idx[CH_W-1:0]]) begin
                any_pend = 1'b1;
                grant_ch = idx[CH_W-1:0];
            end
        end
        if (rise_pend[grant_ch] && fall_pend[grant_ch]) begin
            grant_rising = rise_older[grant_ch];
        end else begin
            grant_rising = rise_pend[grant_ch];
        end
        rr_next = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
        load    = any_pend && ((state_reg == IDLE) || evt_ready);
    end

    // Presentation FSM with registered event outputs and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            evt_valid  <= 1'b0;
            evt_ch     <= '0;
            evt_rising <= 1'b0;
            rr_ptr_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        state_reg  <= PRESENT;
                        evt_valid  <= 1'b1;
                        evt_ch     <= grant_ch;
                        evt_rising <= grant_rising;
                        rr_ptr_reg <= rr_next;
                    end
                end
                PRESENT: begin
                    if (evt_ready) begin
                        if (load) begin
                            evt_ch     <= grant_ch;
                            evt_rising <= grant_rising;
                            rr_ptr_reg <= rr_next;
                        end else begin
                            state_reg <= IDLE;
                            evt_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    evt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter (NUM_CH = 4): directed vector
// table, hand-written corner sequences and a randomized run against a
// queue-based reference model. Overflow checks need EDGE_EVENT_ARBITER_OVERFLOW_EN.
module tb_edge_event_arbiter;
    import edge_event_arbiter_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] signal;
    logic [N-1:0] rise_en;
    logic [N-1:0] fall_en;
    logic         evt_valid;
    logic         evt_ready;
    logic [1:0]   evt_ch;
    logic         evt_rising;
    logic [N-1:0] pending;
    logic [N-1:0] ovf_clr_drv;
`ifdef EDGE_EVENT_ARBITER_OVERFLOW_EN
    logic [N-1:0] ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    edge_event_arbiter #(.NUM_CH(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .signal     (signal),
        .rise_en    (rise_en),
        .fall_en    (fall_en),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_ch     (evt_ch),
        .evt_rising (evt_rising),
        .pending    (pending)
`ifdef EDGE_EVENT_ARBITER_OVERFLOW_EN
        ,
        .ovf        (ovf),
        .ovf_clr    (ovf_clr_drv)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0] sig;
        logic [3:0] fen;
        logic       rdy;
        logic       exp_valid;
        logic [1:0] exp_ch;
        logic       exp_rising;
        logic [3:0] exp_pend;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] s, input logic [3:0] f, input logic r,
                       input logic v, input logic [1:0] c, input logic rr, input logic [3:0] p);
        vec_t t;
        t.sig = s; t.fen = f; t.rdy = r;
        t.exp_valid = v; t.exp_ch = c; t.exp_rising = rr; t.exp_pend = p;
        tbl.push_back(t);
    endtask

    // ---------------- reference model ----------------
    // Each channel keeps its pending edge types in arrival order (1 = rising).
    bit         mq[N][$];
    logic       m_valid;
    edge_evt_t  m_evt;
    int         m_ptr;
    logic [N-1:0] m_prev;
    logic [N-1:0] m_ovf;

    function automatic bit has_type(input int c, input bit t);
        for (int k = 0; k < mq[c].size(); k++) begin
            if (mq[c][k] == t) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_step();
        bit found;
        bit r;
        bit f;
        bit merged;
        int c;
        if (rst) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_valid = 1'b0;
            m_evt   = '0;
            m_ptr   = 0;
            m_ovf   = '0;
            m_prev  = signal;
            return;
        end
        if (!m_valid || evt_ready) begin
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
                c = (m_ptr + i) % N;
                if (!found && mq[c].size() > 0) begin
                    found        = 1'b1;
                    m_evt.ch     = 5'(c);
                    m_evt.rising = mq[c].pop_front();
                    m_ptr        = (c + 1) % N;
                end
            end
            m_valid = found;
        end
        for (int i = 0; i < N; i++) begin
            r = signal[i] & ~m_prev[i] & rise_en[i];
            f = ~signal[i] & m_prev[i] & fall_en[i];
            merged = 1'b0;
            if (r) begin
                if (has_type(i, 1'b1)) merged = 1'b1;
                else mq[i].push_back(1'b1);
            end
            if (f) begin
                if (has_type(i, 1'b0)) merged = 1'b1;
                else mq[i].push_back(1'b0);
            end
            if (merged) m_ovf[i] = 1'b1;
            else if (ovf_clr_drv[i]) m_ovf[i] = 1'b0;
        end
        m_prev = signal;
    endtask

    task automatic compare_model(input int cyc);
        logic [N-1:0] m_pend;
        logic [7:0]   exp_v;
        logic [7:0]   act_v;
        for (int i = 0; i < N; i++) m_pend[i] = (mq[i].size() > 0);
        exp_v = {m_valid, m_valid ? {m_evt.ch[1:0], m_evt.rising} : 3'b000, m_pend};
        act_v = {evt_valid, m_valid ? {evt_ch, evt_rising} : 3'b000, pending};
        check($sformatf("rand_cyc%0d {valid,ch,rising,pending}", cyc), 32'(act_v), 32'(exp_v));
`ifdef EDGE_EVENT_ARBITER_OVERFLOW_EN
        check($sformatf("rand_cyc%0d ovf", cyc), 32'(ovf), 32'(m_ovf));
`endif
    endtask

    task automatic do_reset(input logic [3:0] s);
        rst = 1'b1; signal = s; evt_ready = 1'b0;
        rise_en = 4'hF; fall_en = 4'hF; ovf_clr_drv = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        int nev;
        rst = 1'b1; signal = '0; rise_en = '1; fall_en = '1;
        evt_ready = 1'b0; ovf_clr_drv = '0;

        // ---- reset: lines held high through reset produce no event ----
        do_reset(4'b1111);
        tick();
        check("reset_outputs", 32'({evt_valid, evt_ch, evt_rising, pending}), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("post_reset_idle%0d", i), 32'({evt_valid, pending}), 32'd0);
        end
        $display("[TB] reset: valid=%0b pending=%b", evt_valid, pending);

        // ---- single edge latency on ch2 ----
        do_reset(4'b0000);
        tick();
        evt_ready = 1'b1;
        signal    = 4'b0100;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!evt_valid && cnt < 8);
        check("latency_cycles", 32'(cnt), 32'd2);
        check("latency_event", 32'({evt_ch, evt_rising}), 32'({2'd2, 1'b1}));
        $display("[TB] latency: %0d cycles ch=%0d rising=%0b", cnt, evt_ch, evt_rising);
        nev = evt_valid ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (evt_valid) nev++;
        end
        check("latency_single_event", 32'(nev), 32'd1);

        // ---- table: RR with backpressure, both types, age, enables, collision ----
        add(4'b1011, 4'hF, 0, 0, 0, 0, 4'b1011);
        add(4'b1011, 4'hF, 0, 1, 0, 1, 4'b1010);
        add(4'b1011, 4'hF, 0, 1, 0, 1, 4'b1010);
        add(4'b1011, 4'hF, 0, 1, 0, 1, 4'b1010);
        add(4'b1011, 4'hF, 0, 1, 0, 1, 4'b1010);
        add(4'b1011, 4'hF, 1, 1, 1, 1, 4'b1000);
        add(4'b1011, 4'hF, 1, 1, 3, 1, 4'b0000);
        add(4'b1011, 4'hF, 1, 0, 0, 0, 4'b0000);
        add(4'b0000, 4'hF, 0, 0, 0, 0, 4'b1011);
        add(4'b0000, 4'hF, 1, 1, 0, 0, 4'b1010);
        add(4'b0000, 4'hF, 1, 1, 1, 0, 4'b1000);
        add(4'b0000, 4'hF, 1, 1, 3, 0, 4'b0000);
        add(4'b0000, 4'hF, 1, 0, 0, 0, 4'b0000);
        add(4'b0010, 4'hF, 0, 0, 0, 0, 4'b0010);
        add(4'b0000, 4'hF, 0, 1, 1, 1, 4'b0010);
        add(4'b0000, 4'hF, 1, 1, 1, 0, 4'b0000);
        add(4'b0000, 4'hF, 1, 0, 0, 0, 4'b0000);
        add(4'b0001, 4'hF, 0, 0, 0, 0, 4'b0001);
        add(4'b0011, 4'hF, 0, 1, 0, 1, 4'b0010);
        add(4'b0001, 4'hF, 0, 1, 0, 1, 4'b0010);
        add(4'b0001, 4'hF, 1, 1, 1, 1, 4'b0010);
        add(4'b0001, 4'hF, 1, 1, 1, 0, 4'b0000);
        add(4'b0001, 4'hF, 1, 0, 0, 0, 4'b0000);
        add(4'b0011, 4'hF, 0, 0, 0, 0, 4'b0010);
        add(4'b0011, 4'hF, 0, 1, 1, 1, 4'b0000);
        add(4'b0001, 4'hF, 0, 1, 1, 1, 4'b0010);
        add(4'b0011, 4'hF, 0, 1, 1, 1, 4'b0010);
        add(4'b0011, 4'hF, 1, 1, 1, 0, 4'b0010);
        add(4'b0011, 4'hF, 1, 1, 1, 1, 4'b0000);
        add(4'b0011, 4'hF, 1, 0, 0, 0, 4'b0000);
        add(4'b0010, 4'hE, 1, 0, 0, 0, 4'b0000);
        add(4'b0010, 4'hE, 1, 0, 0, 0, 4'b0000);
        add(4'b0110, 4'hE, 0, 0, 0, 0, 4'b0100);
        add(4'b0111, 4'hE, 0, 1, 2, 1, 4'b0001);
        add(4'b0110, 4'hE, 0, 1, 2, 1, 4'b0001);
        add(4'b0111, 4'hE, 1, 1, 0, 1, 4'b0001);
        add(4'b0111, 4'hE, 1, 1, 0, 1, 4'b0000);
        add(4'b0111, 4'hE, 1, 0, 0, 0, 4'b0000);

        do_reset(4'b0000);
        tick();
        for (int i = 0; i < tbl.size(); i++) begin
            logic [7:0] exp_v;
            logic [7:0] act_v;
            signal    = tbl[i].sig;
            fall_en   = tbl[i].fen;
            rise_en   = 4'hF;
            evt_ready = tbl[i].rdy;
            tick();
            exp_v = {tbl[i].exp_valid, tbl[i].exp_valid ? {tbl[i].exp_ch, tbl[i].exp_rising} : 3'b000,
                     tbl[i].exp_pend};
            act_v = {evt_valid, tbl[i].exp_valid ? {evt_ch, evt_rising} : 3'b000, pending};
            check($sformatf("vec%0d {valid,ch,rising,pending}", i), 32'(act_v), 32'(exp_v));
            $display("[TB] vec %0d: valid=%0b ch=%0d rising=%0b pending=%b",
                     i, evt_valid, evt_ch, evt_rising, pending);
        end

`ifdef EDGE_EVENT_ARBITER_OVERFLOW_EN
        // ---- overflow: two ch3 rises while stalled ----
        do_reset(4'b0000);
        tick();
        fall_en = 4'b0111;
        signal = 4'b0001; tick();
        signal = 4'b1001; tick();
        signal = 4'b0001; tick();
        signal = 4'b1001; tick();
        check("ovf_set", 32'(ovf), 32'(4'b1000));
        check("ovf_pending", 32'(pending), 32'(4'b1000));
        evt_ready = 1'b1;
        nev = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (evt_valid && evt_ch == 2'd3) nev++;
        end
        check("ovf_single_event", 32'(nev), 32'd1);
        check("ovf_sticky", 32'(ovf), 32'(4'b1000));
        ovf_clr_drv = 4'b1000; tick();
        ovf_clr_drv = 4'b0000; tick();
        check("ovf_cleared", 32'(ovf), 32'd0);
        $display("[TB] overflow: ch3 events=%0d ovf=%b", nev, ovf);
`endif

        // ---- randomized run against the reference model ----
        rst = 1'b1; signal = '0; rise_en = '1; fall_en = '1; evt_ready = 1'b0; ovf_clr_drv = '0;
        model_step(); tick(); compare_model(-1);
        rst = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic [N-1:0] tog;
            rst = ($urandom_range(0, 299) == 0);
            for (int b = 0; b < N; b++) tog[b] = ($urandom_range(0, 2) == 0);
            signal      = signal ^ tog;
            rise_en     = ($urandom_range(0, 7) == 0) ? N'($urandom) : '1;
            fall_en     = ($urandom_range(0, 7) == 0) ? N'($urandom) : '1;
            evt_ready   = 1'($urandom_range(0, 1));
            for (int b = 0; b < N; b++) ovf_clr_drv[b] = ($urandom_range(0, 7) == 0);
            if (evt_valid && evt_ready && !rst)
                $display("[TB] rand %0d: accept ch=%0d rising=%0b", cyc, evt_ch, evt_rising);
            model_step();
            tick();
            compare_model(cyc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
